// File: rtl/ls_rs_queue.sv
// rtl/ls_rs_queue.sv - in-order load/store reservation station with CDB wakeup,
// enqueue-time forwarding and an empty-queue bypass into a registered issue port.
module ls_rs_queue #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [OP_W-1:0]             op_i,
  input  logic [DATA_W-1:0]           imm_i,
  input  logic [DATA_W-1:0]           r1_data_i,
  input  logic [DATA_W-1:0]           r2_data_i,
  input  logic [TAG_W-1:0]            r1_tag_i,
  input  logic [TAG_W-1:0]            r2_tag_i,
  input  logic [TAG_W-1:0]            tag_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [OP_W-1:0]             out_op_o,
  output logic [DATA_W-1:0]           out_addr_o,
  output logic [DATA_W-1:0]           out_r2_data_o,
  output logic [TAG_W-1:0]            out_tag_o,
  input  logic [NUM_CDB-1:0]          cdb_en_i,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag_i,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data_i,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  output logic                        empty_o,
  output logic                        full_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  valid_q, r1_rdy_q, r2_rdy_q;
  logic [OP_W-1:0]   op_q      [DEPTH];
  logic [TAG_W-1:0]  tag_q     [DEPTH];
  logic [TAG_W-1:0]  r1_tag_q  [DEPTH];
  logic [TAG_W-1:0]  r2_tag_q  [DEPTH];
  logic [DATA_W-1:0] addr_q    [DEPTH];
  logic [DATA_W-1:0] r2_data_q [DEPTH];
  logic [IDX_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              out_valid_q;
  logic [OP_W-1:0]   out_op_q;
  logic [DATA_W-1:0] out_addr_q, out_r2_data_q;
  logic [TAG_W-1:0]  out_tag_q;

  // {hit, data}; the descending scan lets the lowest-index channel win on duplicate tags
  function automatic logic [DATA_W:0] cdb_match(input logic [TAG_W-1:0] t);
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (cdb_en_i[k] && cdb_tag_i[k*TAG_W +: TAG_W] == t)
        r = {1'b1, cdb_data_i[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  logic [DATA_W:0]   f1, f2;
  logic              in_r1_rdy, in_r2_rdy;
  logic [DATA_W-1:0] in_r1_val, in_r2_val, in_addr;
  logic              enq_fire, can_load, head_rdy, issue, bypass, push;
  logic [DATA_W:0]   m1 [DEPTH];
  logic [DATA_W:0]   m2 [DEPTH];
  logic [DEPTH-1:0]  cap1, cap2;

  always_comb begin
    f1        = cdb_match(r1_tag_i);
    f2        = cdb_match(r2_tag_i);
    in_r1_rdy = (r1_tag_i == '0) || f1[DATA_W];
    in_r2_rdy = (r2_tag_i == '0) || f2[DATA_W];
    in_r1_val = (r1_tag_i == '0) ? r1_data_i : f1[DATA_W-1:0];
    in_r2_val = (r2_tag_i == '0) ? r2_data_i : f2[DATA_W-1:0];
    in_addr   = in_r1_rdy ? imm_i + in_r1_val : imm_i;

    enq_fire  = in_valid_i && in_ready_o && rdy;
    can_load  = !out_valid_q || out_ready_i;
    head_rdy  = valid_q[head_q] && r1_rdy_q[head_q] && r2_rdy_q[head_q];
    issue     = head_rdy && can_load;
    bypass    = enq_fire && (count_q == '0) && in_r1_rdy && in_r2_rdy && can_load;
    push      = enq_fire && !bypass;

    for (int i = 0; i < DEPTH; i++) begin
      m1[i]   = cdb_match(r1_tag_q[i]);
      m2[i]   = cdb_match(r2_tag_q[i]);
      cap1[i] = valid_q[i] && !r1_rdy_q[i] && m1[i][DATA_W];
      cap2[i] = valid_q[i] && !r2_rdy_q[i] && m2[i][DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (rdy && flush_i)) begin
      valid_q     <= '0;
      r1_rdy_q    <= '0;
      r2_rdy_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cap1[i]) r1_rdy_q[i] <= 1'b1;
        if (cap2[i]) r2_rdy_q[i] <= 1'b1;
      end
      if (issue) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push) begin
        valid_q[tail_q]  <= 1'b1;
        r1_rdy_q[tail_q] <= in_r1_rdy;
        r2_rdy_q[tail_q] <= in_r2_rdy;
        tail_q           <= tail_q + 1'b1;
      end
      case ({push, issue})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (issue || bypass)
        out_valid_q <= 1'b1;
      else if (out_valid_q && out_ready_i)
        out_valid_q <= 1'b0;
    end
  end

  // Payload storage carries no reset; validity lives entirely in the control bits above
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cap1[i]) addr_q[i]    <= addr_q[i] + m1[i][DATA_W-1:0];
        if (cap2[i]) r2_data_q[i] <= m2[i][DATA_W-1:0];
      end
      if (push) begin
        op_q[tail_q]      <= op_i;
        tag_q[tail_q]     <= tag_i;
        r1_tag_q[tail_q]  <= r1_tag_i;
        r2_tag_q[tail_q]  <= r2_tag_i;
        addr_q[tail_q]    <= in_addr;
        r2_data_q[tail_q] <= in_r2_val;
      end
      if (issue) begin
        out_op_q      <= op_q[head_q];
        out_addr_q    <= addr_q[head_q];
        out_r2_data_q <= r2_data_q[head_q];
        out_tag_q     <= tag_q[head_q];
      end else if (bypass) begin
        out_op_q      <= op_i;
        out_addr_q    <= in_addr;
        out_r2_data_q <= in_r2_val;
        out_tag_q     <= tag_i;
      end
    end
  end

  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign in_ready_o    = !full_o;
  assign out_valid_o   = out_valid_q;
  assign out_op_o      = out_op_q;
  assign out_addr_o    = out_addr_q;
  assign out_r2_data_o = out_r2_data_q;
  assign out_tag_o     = out_tag_q;

endmodule

// File: tb/tb_ls_rs_queue.sv
// tb/tb_ls_rs_queue.sv - directed and randomized checks of ls_rs_queue against
// a queue-based behavioural model.
module tb_ls_rs_queue;
  localparam int DEPTH   = 8;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int OP_W    = 6;
  localparam int NUM_CDB = 2;
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic                       clk = 1'b0;
  logic                       rst, rdy, flush_i, in_valid_i, in_ready_o;
  logic [OP_W-1:0]            op_i;
  logic [DATA_W-1:0]          imm_i, r1_data_i, r2_data_i;
  logic [TAG_W-1:0]           r1_tag_i, r2_tag_i, tag_i;
  logic                       out_valid_o, out_ready_i;
  logic [OP_W-1:0]            out_op_o;
  logic [DATA_W-1:0]          out_addr_o, out_r2_data_o;
  logic [TAG_W-1:0]           out_tag_o;
  logic [NUM_CDB-1:0]         cdb_en_i;
  logic [NUM_CDB*TAG_W-1:0]   cdb_tag_i;
  logic [NUM_CDB*DATA_W-1:0]  cdb_data_i;
  logic [CNT_W-1:0]           count_o;
  logic                       empty_o, full_o;

  always #5 clk = ~clk;

  ls_rs_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .imm_i(imm_i), .r1_data_i(r1_data_i), .r2_data_i(r2_data_i),
    .r1_tag_i(r1_tag_i), .r2_tag_i(r2_tag_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_op_o(out_op_o), .out_addr_o(out_addr_o), .out_r2_data_o(out_r2_data_o),
    .out_tag_o(out_tag_o),
    .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag, r1t, r2t;
    logic [DATA_W-1:0] addr, r2d;
    bit                r1r, r2r;
  } ent_t;

  ent_t mq[$];
  ent_t m_out;
  bit   m_ov = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit cdb_find(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
    d = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_en_i[k] && cdb_tag_i[k*TAG_W +: TAG_W] == t) begin
        d = cdb_data_i[k*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock of the reference behaviour, using the inputs held across the edge
  task automatic model_step();
    ent_t ne;
    bit accept, can_load, issue, bypass, hit;
    logic [DATA_W-1:0] d;
    if (rst) begin mq.delete(); m_ov = 1'b0; return; end
    if (!rdy) return;
    if (flush_i) begin mq.delete(); m_ov = 1'b0; return; end
    accept   = in_valid_i && (mq.size() < DEPTH);
    can_load = !m_ov || out_ready_i;
    issue    = (mq.size() > 0) && mq[0].r1r && mq[0].r2r && can_load;
    ne.op = op_i; ne.tag = tag_i; ne.r1t = r1_tag_i; ne.r2t = r2_tag_i;
    ne.r1r = (r1_tag_i == 0);
    d = r1_data_i;
    if (!ne.r1r) ne.r1r = cdb_find(r1_tag_i, d);
    ne.addr = ne.r1r ? imm_i + d : imm_i;
    ne.r2r = (r2_tag_i == 0);
    ne.r2d = r2_data_i;
    if (!ne.r2r) begin
      hit = cdb_find(r2_tag_i, d);
      if (hit) begin ne.r2r = 1'b1; ne.r2d = d; end
    end
    bypass = accept && (mq.size() == 0) && ne.r1r && ne.r2r && can_load;
    foreach (mq[i]) begin
      hit = cdb_find(mq[i].r1t, d);
      if (!mq[i].r1r && hit) begin mq[i].addr = mq[i].addr + d; mq[i].r1r = 1'b1; end
      hit = cdb_find(mq[i].r2t, d);
      if (!mq[i].r2r && hit) begin mq[i].r2d = d; mq[i].r2r = 1'b1; end
    end
    if (issue) begin m_out = mq.pop_front(); m_ov = 1'b1; end
    else if (bypass) begin m_out = ne; m_ov = 1'b1; end
    else if (m_ov && out_ready_i) m_ov = 1'b0;
    if (accept && !bypass) mq.push_back(ne);
  endtask

  task automatic compare();
    check("count", count_o, mq.size());
    check("empty", empty_o, mq.size() == 0);
    check("full", full_o, mq.size() == DEPTH);
    check("in_ready", in_ready_o, mq.size() < DEPTH);
    check("out_valid", out_valid_o, m_ov);
    if (m_ov) begin
      check("out_op", out_op_o, m_out.op);
      check("out_addr", out_addr_o, m_out.addr);
      check("out_r2_data", out_r2_data_o, m_out.r2d);
      check("out_tag", out_tag_o, m_out.tag);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    flush_i = 1'b0; in_valid_i = 1'b0; op_i = '0; imm_i = '0;
    r1_data_i = '0; r2_data_i = '0; r1_tag_i = '0; r2_tag_i = '0; tag_i = '0;
    cdb_en_i = '0; cdb_tag_i = '0; cdb_data_i = '0;
  endtask

  task automatic enq(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] imm,
                     input logic [TAG_W-1:0] r1t, input logic [DATA_W-1:0] r1d,
                     input logic [TAG_W-1:0] r2t, input logic [DATA_W-1:0] r2d,
                     input logic [TAG_W-1:0] tag);
    in_valid_i = 1'b1; op_i = op; imm_i = imm;
    r1_tag_i = r1t; r1_data_i = r1d; r2_tag_i = r2t; r2_data_i = r2d; tag_i = tag;
  endtask

  initial begin
    int n;
    idle();
    rst = 1'b1; rdy = 1'b1; out_ready_i = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);

    // Empty-queue bypass
    enq(3, 'h10, 0, 'h100, 0, 0, 5);
    cycle();
    in_valid_i = 1'b0;
    check("byp_valid", out_valid_o, 1);
    check("byp_addr", out_addr_o, 'h110);
    check("byp_tag", out_tag_o, 5);
    check("byp_count", count_o, 0);
    cycle();

    // CDB wakeup on channel 1, bystander waits on tag 3
    enq(1, 4, 7, 0, 0, 'h55, 1);
    cycle();
    enq(2, 8, 3, 0, 0, 'h66, 2);
    cycle();
    in_valid_i = 1'b0;
    cdb_en_i = 2'b10; cdb_tag_i = {4'd7, 4'd0}; cdb_data_i = {32'h200, 32'h0};
    cycle();
    cdb_en_i = '0;
    cycle();
    check("wake_valid", out_valid_o, 1);
    check("wake_addr", out_addr_o, 'h204);
    check("wake_tag", out_tag_o, 1);
    check("wake_count", count_o, 1);
    cycle();
    check("wake_bystander_blocked", out_valid_o, 0);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    check("wake_flush_count", count_o, 0);

    // In-order issue with backpressure
    out_ready_i = 1'b0;
    enq(4, 0, 2, 0, 0, 'h77, 3);
    cycle();
    enq(5, 'h20, 0, 'h1000, 0, 'h88, 4);
    cycle();
    in_valid_i = 1'b0;
    cycle();
    check("ord_blocked_valid", out_valid_o, 0);
    check("ord_blocked_count", count_o, 2);
    cdb_en_i = 2'b01; cdb_tag_i = {4'd0, 4'd2}; cdb_data_i = {32'h0, 32'h40};
    cycle();
    cdb_en_i = '0;
    cycle();
    check("ord_first_tag", out_tag_o, 3);
    check("ord_first_addr", out_addr_o, 'h40);
    cycle();
    check("ord_hold_valid", out_valid_o, 1);
    check("ord_hold_tag", out_tag_o, 3);
    out_ready_i = 1'b1;
    cycle();
    check("ord_second_tag", out_tag_o, 4);
    check("ord_second_addr", out_addr_o, 'h1020);
    cycle();
    check("ord_done_valid", out_valid_o, 0);

    // Fill to capacity, reject the ninth, drain in order, then refill across the wrap
    for (int i = 0; i < DEPTH; i++) begin
      enq(OP_W'(i), DATA_W'(i * 4), 9, 0, 0, DATA_W'(i), TAG_W'(i + 1));
      cycle();
    end
    in_valid_i = 1'b0;
    check("full_flag", full_o, 1);
    check("full_in_ready", in_ready_o, 0);
    enq('h3f, 0, 0, 0, 0, 0, 15);
    cycle();
    in_valid_i = 1'b0;
    check("full_reject_count", count_o, DEPTH);
    cdb_en_i = 2'b01; cdb_tag_i = {4'd0, 4'd9}; cdb_data_i = {32'h0, 32'h1000};
    cycle();
    cdb_en_i = '0;
    n = 0;
    for (int c = 0; c < 40 && n < DEPTH; c++) begin
      cycle();
      if (out_valid_o) begin
        check("full_order_tag", out_tag_o, n + 1);
        n++;
      end
    end
    check("full_issued", n, DEPTH);
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enq(OP_W'(20 + i), DATA_W'(i), 0, 'h300, 0, 0, TAG_W'(10 + i));
      cycle();
    end
    in_valid_i = 1'b0;
    check("wrap_count", count_o, 3);
    out_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      cycle();
      if (out_valid_o) begin
        check("wrap_order_tag", out_tag_o, 10 + n);
        n++;
      end
    end
    check("wrap_issued", n, 3);
    cycle();

    // Enqueue-time forwarding of store data
    enq(7, 8, 0, 'h10, 6, 'hdead, 6);
    cdb_en_i = 2'b01; cdb_tag_i = {4'd0, 4'd6}; cdb_data_i = {32'h0, 32'hABCD};
    cycle();
    in_valid_i = 1'b0; cdb_en_i = '0;
    check("fwd_valid", out_valid_o, 1);
    check("fwd_r2_data", out_r2_data_o, 'hABCD);
    check("fwd_addr", out_addr_o, 'h18);
    cycle();

    // rdy freeze then flush over an enqueue
    for (int i = 0; i < 5; i++) begin
      enq(1, 0, 11, 0, 0, 0, TAG_W'(i + 1));
      cycle();
    end
    check("pre_freeze_count", count_o, 5);
    rdy = 1'b0;
    enq(2, 0, 0, 0, 0, 0, 13);
    cdb_en_i = 2'b01; cdb_tag_i = {4'd0, 4'd11}; cdb_data_i = {32'h0, 32'h1};
    cycle();
    check("freeze_count", count_o, 5);
    check("freeze_valid", out_valid_o, 0);
    rdy = 1'b1; cdb_en_i = '0; flush_i = 1'b1;
    cycle();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("flush_count", count_o, 0);
    check("flush_valid", out_valid_o, 0);
    check("flush_empty", empty_o, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy         = ($urandom_range(0, 15) != 0);
      flush_i     = ($urandom_range(0, 99) == 0);
      in_valid_i  = 1'($urandom_range(0, 1));
      op_i        = OP_W'($urandom);
      imm_i       = DATA_W'($urandom);
      r1_data_i   = DATA_W'($urandom);
      r2_data_i   = DATA_W'($urandom);
      r1_tag_i    = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, 7));
      r2_tag_i    = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, 7));
      tag_i       = TAG_W'($urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_en_i[k] = rdy && ($urandom_range(0, 2) == 0);
        cdb_tag_i[k*TAG_W +: TAG_W]    = TAG_W'($urandom_range(1, 7));
        cdb_data_i[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
